// File: rtl/regfile_wb.sv
// Architectural integer register file with a valid/ready write port, two bypassed
// combinational read ports and a post-reset sweep that clears x1..x(NREGS-1).
module regfile_wb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            busy
);

    typedef enum logic [0:0] {StClear, StReady} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;

    // x0 is hardwired to zero, so storage starts at x1.
    logic [XLEN-1:0] regs_q [NREGS-1:1];

    logic            reg_we;
    logic [AW-1:0]   reg_waddr;
    logic [XLEN-1:0] reg_wdata;
    logic            wr_fire;

    assign wr_ready = (state_q == StReady) && !reset;
    assign busy     = !wr_ready;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reg_we    = 1'b0;
        reg_waddr = wr_addr;
        reg_wdata = wr_data;
        unique case (state_q)
            StClear: begin
                reg_we    = 1'b1;
                reg_waddr = cnt_q;
                reg_wdata = '0;
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            StReady: begin
                reg_we = wr_fire && (wr_addr != '0);
            end
            default: begin
                state_d = StClear;
                cnt_d   = AW'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (reg_we) begin
                regs_q[reg_waddr] <= reg_wdata;
            end
        end
    end

    // Reads are masked to zero until the sweep has made every register defined.
    always_comb begin
        rs1_data = '0;
        if (!busy && (rs1_addr != '0)) begin
            if (wr_fire && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (!busy && (rs2_addr != '0)) begin
            if (wr_fire && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

endmodule
